// File: rtl/sin_cordic.sv
// Iterative rotation-mode CORDIC: signed Q2.14 angle in, sin/cos out.
// One micro-rotation per clock; START/VALID handshake, clamped input range.
module sin_cordic #(
  parameter int ITER  = 14,
  parameter int GUARD = 2
) (
  input  logic        CLK_I,
  input  logic        RST_N_I,
  input  logic        START_I,
  input  logic [15:0] DATA_I,
  output logic [15:0] DATA_O,
  output logic [15:0] COS_O,
  output logic        VALID_O,
  output logic        BUSY_O,
  output logic        SAT_O
);

  localparam int W = 16 + GUARD + 1;

  typedef logic signed [W-1:0] dp_t;

  localparam dp_t X0   = dp_t'(9949 * (2 ** GUARD));
  localparam dp_t RND  = (GUARD > 0) ? dp_t'(2 ** (GUARD - 1)) : '0;
  localparam dp_t OMAX = dp_t'(16384);
  localparam dp_t OMIN = -OMAX;

  localparam logic signed [15:0] AMAX = 16'sd25736;
  localparam logic signed [15:0] AMIN = -16'sd25736;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  dp_t         x_q;
  dp_t         y_q;
  dp_t         z_q;
  dp_t         x_d;
  dp_t         y_d;
  dp_t         z_d;
  logic        satc_q;
  logic [15:0] sin_q;
  logic [15:0] cos_q;
  logic        valid_q;
  logic        busy_q;
  logic        sat_q;

  logic signed [15:0] din;
  logic signed [15:0] ang;
  logic               ang_sat;
  dp_t                z_ld;
  dp_t                at;

  function automatic dp_t atan_lut(input logic [3:0] i);
    logic [15:0] a;
    case (i)
      4'd0:    a = 16'd12868;
      4'd1:    a = 16'd7596;
      4'd2:    a = 16'd4014;
      4'd3:    a = 16'd2037;
      4'd4:    a = 16'd1023;
      4'd5:    a = 16'd512;
      4'd6:    a = 16'd256;
      4'd7:    a = 16'd128;
      4'd8:    a = 16'd64;
      4'd9:    a = 16'd32;
      4'd10:   a = 16'd16;
      4'd11:   a = 16'd8;
      4'd12:   a = 16'd4;
      4'd13:   a = 16'd2;
      default: a = 16'd0;
    endcase
    return dp_t'({{(W-16){1'b0}}, a}) <<< GUARD;
  endfunction

  // Drop guard bits with round-half-up, then clamp to +/-1.0.
  function automatic logic [15:0] out_sat(input dp_t v);
    dp_t r;
    r = (v + RND) >>> GUARD;
    if (r > OMAX) begin
      return OMAX[15:0];
    end else if (r < OMIN) begin
      return OMIN[15:0];
    end
    return r[15:0];
  endfunction

  always_comb begin
    din     = $signed(DATA_I);
    ang_sat = (din > AMAX) || (din < AMIN);
    ang     = din;
    if (din > AMAX) begin
      ang = AMAX;
    end else if (din < AMIN) begin
      ang = AMIN;
    end
    z_ld = dp_t'({{(W-16){ang[15]}}, ang}) <<< GUARD;
  end

  always_comb begin
    at = atan_lut(cnt_q);
    if (!z_q[W-1]) begin
      x_d = x_q - (y_q >>> cnt_q);
      y_d = y_q + (x_q >>> cnt_q);
      z_d = z_q - at;
    end else begin
      x_d = x_q + (y_q >>> cnt_q);
      y_d = y_q - (x_q >>> cnt_q);
      z_d = z_q + at;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      satc_q  <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START_I) begin
            x_q     <= X0;
            y_q     <= '0;
            z_q     <= z_ld;
            cnt_q   <= '0;
            satc_q  <= ang_sat;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            sin_q   <= out_sat(y_d);
            cos_q   <= out_sat(x_d);
            sat_q   <= satc_q;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign DATA_O  = sin_q;
  assign COS_O   = cos_q;
  assign VALID_O = valid_q;
  assign BUSY_O  = busy_q;
  assign SAT_O   = sat_q;

endmodule

// File: tb/tb_sin_cordic.sv
// Directed bench for sin_cordic: handshake timing, clamping,
// async reset and a sin/cos sweep against a real-valued model.
module tb_sin_cordic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] DATA_O;
  logic [15:0] COS_O;
  logic        VALID_O;
  logic        BUSY_O;
  logic        SAT_O;

  int nvec = 0;
  int nbad = 0;

  sin_cordic dut (
    .CLK_I  (clk),
    .RST_N_I(rst_n),
    .START_I(start),
    .DATA_I (din),
    .DATA_O (DATA_O),
    .COS_O  (COS_O),
    .VALID_O(VALID_O),
    .BUSY_O (BUSY_O),
    .SAT_O  (SAT_O)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs,
                         input int exp, input int tol);
    bit in_rng;
    in_rng = (obs >= exp - tol) && (obs <= exp + tol);
    nvec++;
    assert (in_rng === 1'b1) else begin
      nbad++;
      $error("FAIL %s: observed %0d expected %0d+/-%0d",
             tag, obs, exp, tol);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic run_op(input int ang, output int s,
                        output int c, output int sat);
    int lat;
    @(negedge clk);
    din   = 16'(ang);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    chk("busy_run", int'(BUSY_O), 1);
    while (VALID_O !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 15);
    s   = s16(DATA_O);
    c   = s16(COS_O);
    sat = int'(SAT_O);
  endtask

  int s, c, sat;
  int npls, first, prev, ival;
  int cyc;
  int maxe;
  int es, ec;
  real rs, rc;
  int ms, mc;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data", int'(DATA_O), 0);
    chk("rst_cos", int'(COS_O), 0);
    chk("rst_valid", int'(VALID_O), 0);
    chk("rst_busy", int'(BUSY_O), 0);
    chk("rst_sat", int'(SAT_O), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Angle 0
    run_op(0, s, c, sat);
    chk_tol("sin0", s, 0, 4);
    chk_tol("cos0", c, 16382, 2);
    chk("sat0", sat, 0);
    @(negedge clk);
    chk("valid_1cyc", int'(VALID_O), 0);

    // pi/6 and -pi/2
    run_op(8579, s, c, sat);
    chk_tol("sin_pi6", s, 8192, 4);
    chk_tol("cos_pi6", c, 14189, 4);
    run_op(-25736, s, c, sat);
    chk_tol("sin_mpi2", s, -16384, 4);
    chk_tol("cos_mpi2", c, 0, 4);
    chk("sat_mpi2", sat, 0);

    // Clamped input
    run_op(32767, s, c, sat);
    chk("sat_7fff", sat, 1);
    chk_tol("sin_7fff", s, 16384, 4);

    // START during RUN ignored; outputs held until completion
    @(negedge clk);
    din   = 16'd8579;
    start = 1'b1;
    npls  = 0;
    first = 0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 5) begin
        chk("hold_sat", int'(SAT_O), 1);
        chk_tol("hold_data", s16(DATA_O), 16384, 4);
        din   = -16'sd8579;
        start = 1'b1;
      end
      if (VALID_O === 1'b1) begin
        npls++;
        if (first == 0) begin
          first = i;
          chk_tol("ign_sin", s16(DATA_O), 8192, 4);
          chk_tol("ign_cos", s16(COS_O), 14189, 4);
          chk("ign_sat", int'(SAT_O), 0);
        end
      end
    end
    chk("ign_npulse", npls, 1);
    chk("ign_lat", first, 15);

    run_op(0, s, c, sat);
    chk("sat_clear", sat, 0);

    // START held high: back-to-back ops
    @(negedge clk);
    din   = 16'd12868;
    start = 1'b1;
    npls  = 0;
    first = 0;
    prev  = 0;
    ival  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk("busy_vs_valid", int'(BUSY_O), int'(!VALID_O));
      if (VALID_O === 1'b1) begin
        npls++;
        if (first == 0) first = i;
        if (prev != 0) ival = i - prev;
        prev = i;
        chk_tol("b2b_sin", s16(DATA_O), 11585, 4);
        chk_tol("b2b_cos", s16(COS_O), 11585, 4);
      end
    end
    start = 1'b0;
    chk("b2b_npulse", npls, 2);
    chk("b2b_first", first, 15);
    chk("b2b_period", ival, 15);
    cyc = 40;
    while (VALID_O !== 1'b1 && cyc < 70) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_last", cyc, 45);

    // Async reset mid-RUN
    @(negedge clk);
    din   = 16'd12868;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_data", int'(DATA_O), 0);
    chk("arst_cos", int'(COS_O), 0);
    chk("arst_valid", int'(VALID_O), 0);
    chk("arst_busy", int'(BUSY_O), 0);
    chk("arst_sat", int'(SAT_O), 0);
    #2 rst_n = 1'b1;
    npls = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (VALID_O === 1'b1 || BUSY_O === 1'b1) npls++;
    end
    chk("arst_quiet", npls, 0);
    run_op(-12868, s, c, sat);
    chk_tol("arst_sin", s, -11585, 4);
    chk_tol("arst_cos2", c, 11585, 4);

    // Sweep against real model
    maxe = 0;
    for (int a = -25736; a <= 25736; a += 97) begin
      run_op(a, s, c, sat);
      rs = $sin(real'(a) / 16384.0) * 16384.0;
      rc = $cos(real'(a) / 16384.0) * 16384.0;
      ms = $rtoi(rs + ((rs >= 0.0) ? 0.5 : -0.5));
      mc = $rtoi(rc + ((rc >= 0.0) ? 0.5 : -0.5));
      if (ms > 16384) ms = 16384;
      if (ms < -16384) ms = -16384;
      if (mc > 16384) mc = 16384;
      chk_tol("sweep_sin", s, ms, 4);
      chk_tol("sweep_cos", c, mc, 4);
      es = (s > ms) ? s - ms : ms - s;
      ec = (c > mc) ? c - mc : mc - c;
      if (es > maxe) maxe = es;
      if (ec > maxe) maxe = ec;
    end
    $display("sweep max |err| = %0d LSB", maxe);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
